// File: rtl/bit_pattern_serializer.sv
// Parallel-to-serial pattern source feeding x/clk/z sequence detectors.
// Shifts a loaded pattern out MSB-first, one bit per enabled clock, with optional looping.
module bit_pattern_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [CNT_W-1:0] i_len_in,
    input  logic             i_loop,
    input  logic             i_en,
    output logic             o_x_out,
    output logic             o_x_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_saved_pat;
    logic [CNT_W-1:0] r_saved_len;
    logic [CNT_W-1:0] r_count;
    logic             r_x_out;
    logic             r_x_valid;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] w_saved_pat_nxt;
    logic [CNT_W-1:0] w_saved_len_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_x_out_nxt;
    logic             w_x_valid_nxt;
    logic             w_done_nxt;

    logic [31:0]      w_len_ext;
    logic             w_len_clamp;
    logic [CNT_W-1:0] w_eff_len;

    // A zero or over-long request means "send the whole register".
    assign w_len_ext   = 32'(i_len_in);
    assign w_len_clamp = (i_len_in == '0) || (w_len_ext > WIDTH);
    assign w_eff_len   = w_len_clamp ? LEN_MAX : i_len_in;

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_saved_pat_nxt = r_saved_pat;
        w_saved_len_nxt = r_saved_len;
        w_count_nxt     = r_count;
        w_x_out_nxt     = r_x_out;
        w_x_valid_nxt   = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_shreg_nxt     = i_data_in;
                    w_saved_pat_nxt = i_data_in;
                    w_saved_len_nxt = w_eff_len;
                    w_count_nxt     = w_eff_len;
                    w_state_nxt     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_en) begin
                    w_x_out_nxt   = r_shreg[WIDTH-1];
                    w_x_valid_nxt = 1'b1;
                    w_shreg_nxt   = r_shreg << 1;
                    w_count_nxt   = r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Single-cycle state; loop is sampled here, so a late drop ends the run.
                w_done_nxt = 1'b1;
                if (i_loop) begin
                    w_shreg_nxt = r_saved_pat;
                    w_count_nxt = r_saved_len;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_saved_pat <= '0;
            r_saved_len <= '0;
            r_count     <= '0;
            r_x_out     <= 1'b0;
            r_x_valid   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_saved_pat <= w_saved_pat_nxt;
            r_saved_len <= w_saved_len_nxt;
            r_count     <= w_count_nxt;
            r_x_out     <= w_x_out_nxt;
            r_x_valid   <= w_x_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_x_out   = r_x_out;
    assign o_x_valid = r_x_valid;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;

endmodule
